// File: rtl/prng_multi_pkg.sv
// Shared types, default constants and seed helpers for the multi-channel PRNG.
package prng_multi_pkg;

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [63:0] DEF_LFSR_TAPS   = 64'h500_0008_0001;
  localparam logic [63:0] DEF_SEED_STRIDE = 64'h1F_3A5C_9E37;

  // Truncate a load value to w bits; an all-zero result becomes 1 so the register never locks up.
  function automatic logic [63:0] nonzero_load(input logic [63:0] v, input int unsigned w);
    logic [63:0] m;
    logic [63:0] r;
    m = (w >= 64) ? '1 : ((64'(1) << w) - 64'(1));
    r = v & m;
    return (r == '0) ? 64'(1) : r;
  endfunction

  function automatic logic [63:0] channel_seed(input logic [63:0] seed, input logic [63:0] ch,
                                               input logic [63:0] stride);
    return seed ^ (ch * stride);
  endfunction

endpackage

// File: rtl/prng_multi_channel.sv
// One generator lane: Fibonacci LFSR plus a rule-90/150 cellular automaton, XOR-combined.
module prng_multi_channel
  import prng_multi_pkg::*;
#(
  parameter int unsigned           LFSR_SIZE = 43,
  parameter logic [LFSR_SIZE-1:0]  LFSR_TAPS = LFSR_SIZE'(DEF_LFSR_TAPS),
  parameter int unsigned           CA_SIZE   = 37,
  parameter int unsigned           CA_R150   = 28,
  parameter int unsigned           OUT_SIZE  = 32
) (
  input  logic                 clock,
  input  logic                 load,
  input  logic                 step,
  input  logic [LFSR_SIZE-1:0] load_value,
  output logic [OUT_SIZE-1:0]  sample
);

  localparam logic [CA_SIZE-1:0] R150_MASK = CA_SIZE'(1) << CA_R150;

  logic [LFSR_SIZE-1:0] sr_q, sr_d;
  logic [CA_SIZE-1:0]   ca_q, ca_d;

  // Load wins over step; both registers hold otherwise.
  always_comb begin
    sr_d = sr_q;
    ca_d = ca_q;
    if (load) begin
      sr_d = LFSR_SIZE'(nonzero_load(64'(load_value), LFSR_SIZE));
      ca_d = CA_SIZE'(nonzero_load(64'(load_value), CA_SIZE));
    end else if (step) begin
      sr_d = {sr_q[LFSR_SIZE-2:0], ^(sr_q & LFSR_TAPS)};
      ca_d = {1'b0, ca_q[CA_SIZE-1:1]} ^ {ca_q[CA_SIZE-2:0], 1'b0} ^ (ca_q & R150_MASK);
    end
  end

  always_ff @(posedge clock) begin
    sr_q <= sr_d;
    ca_q <= ca_d;
  end

  assign sample = ca_q[OUT_SIZE-1:0] ^ sr_q[OUT_SIZE-1:0];

endmodule

// File: rtl/prng_multi.sv
// Multi-channel hybrid PRNG: warm-up FSM, per-channel seeding and a valid/ready output register.
module prng_multi
  import prng_multi_pkg::*;
#(
  parameter int unsigned           LFSR_SIZE   = 43,
  parameter logic [LFSR_SIZE-1:0]  LFSR_TAPS   = LFSR_SIZE'(DEF_LFSR_TAPS),
  parameter int unsigned           CA_SIZE     = 37,
  parameter int unsigned           CA_R150     = 28,
  parameter int unsigned           OUT_SIZE    = 32,
  parameter int unsigned           NUM_CH      = 4,
  parameter int unsigned           WARMUP      = 64,
  parameter logic [LFSR_SIZE-1:0]  SEED_STRIDE = LFSR_SIZE'(DEF_SEED_STRIDE)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [LFSR_SIZE-1:0]       seed,
  input  logic                       reseed,
  input  logic                       enable,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [NUM_CH*OUT_SIZE-1:0] randomArray,
  output logic                       warming
);

  localparam int unsigned CNT_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int unsigned BEAT_W = NUM_CH * OUT_SIZE;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [BEAT_W-1:0]   data_q, data_d;
  logic                warming_q, warming_d;
  logic                ch_load, ch_step;
  logic [BEAT_W-1:0]   sample_all;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [LFSR_SIZE-1:0] ch_seed;
    assign ch_seed = LFSR_SIZE'(channel_seed(64'(seed), 64'(c), 64'(SEED_STRIDE)));

    prng_multi_channel #(
      .LFSR_SIZE (LFSR_SIZE),
      .LFSR_TAPS (LFSR_TAPS),
      .CA_SIZE   (CA_SIZE),
      .CA_R150   (CA_R150),
      .OUT_SIZE  (OUT_SIZE)
    ) u_ch (
      .clock      (clock),
      .load       (ch_load),
      .step       (ch_step),
      .load_value (ch_seed),
      .sample     (sample_all[c*OUT_SIZE +: OUT_SIZE])
    );
  end

  // Next-state, generator control and output register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    ch_load     = 1'b0;
    ch_step     = 1'b0;
    if (reset) begin
      ch_load = 1'b1;
    end else if (reseed) begin
      state_d     = ST_WARM;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      ch_load     = 1'b1;
    end else begin
      case (state_q)
        ST_WARM: begin
          ch_step = 1'b1;
          if (cnt_q == CNT_W'(WARMUP - 1)) state_d = ST_RUN;
          else                             cnt_d   = cnt_q + CNT_W'(1);
        end
        ST_RUN: begin
          if (enable && (!out_valid_q || out_ready)) begin
            data_d      = sample_all;
            out_valid_d = 1'b1;
            ch_step     = 1'b1;
          end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        default: state_d = ST_WARM;
      endcase
    end
    warming_d = (state_d == ST_WARM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_WARM;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      warming_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      warming_q   <= warming_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign randomArray = data_q;
  assign warming     = warming_q;

endmodule
